// File: rtl/opsum_pkg.sv
// rtl/opsum_pkg.sv - shared state type, widths and base/total helper for the opsum GLB writer
package opsum_pkg;
   localparam int PARAM_W_DEF    = 8;
   localparam int GLB_ADDR_W_DEF = 16;
   localparam int CNT_W_DEF      = 16;
   localparam int DATA_W_DEF     = 32;
   localparam int BYTES_PER_WORD = 4;
   // Intermediates wider than the address/count; results only matter modulo 2^16.
   localparam int CALC_W         = 32;

   typedef enum logic [2:0] {IDLE, CALC1, CALC2, WRITE, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [GLB_ADDR_W_DEF-1:0] base;
      logic [CNT_W_DEF-1:0]      total;
   } calc_res_t;

   function automatic calc_res_t calc_base_total(
      input logic [CALC_W-1:0] p, t, q, r, e, stride,
      input logic [CALC_W-1:0] filt_row, filt_col, ifmap_col, ofmap_col);
      logic [CALC_W-1:0] pt, qr, span;
      calc_res_t         res;
      pt         = p * t;
      qr         = q * r;
      span       = stride * (e - CALC_W'(1)) + filt_col;
      res.base   = GLB_ADDR_W_DEF'(qr * span * ifmap_col + pt * qr * filt_row * filt_col
                                   + pt * CALC_W'(BYTES_PER_WORD));
      res.total  = CNT_W_DEF'(pt * e * ofmap_col);
      return res;
   endfunction
endpackage

// File: rtl/opsum_glb_writer_if.sv
// rtl/opsum_glb_writer_if.sv - opsum stream input and GLB byte-write port bundle
interface opsum_glb_writer_if #(
   parameter int DATA_W     = 32,
   parameter int GLB_ADDR_W = 16
);
   logic                  opsum_valid;
   logic [DATA_W-1:0]     opsum_data;
   logic                  opsum_ready;
   logic                  glb_we;
   logic [GLB_ADDR_W-1:0] glb_addr;
   logic [DATA_W-1:0]     glb_wdata;

   modport master (
      input  opsum_valid, opsum_data,
      output opsum_ready, glb_we, glb_addr, glb_wdata
   );
   modport slave (
      output opsum_valid, opsum_data,
      input  opsum_ready, glb_we, glb_addr, glb_wdata
   );
endinterface

// File: rtl/opsum_addr_calc.sv
// rtl/opsum_addr_calc.sv - two-stage registered computation of opsum region base and word total
module opsum_addr_calc
   import opsum_pkg::*;
#(
   parameter int PARAM_W    = PARAM_W_DEF,
   parameter int GLB_ADDR_W = GLB_ADDR_W_DEF,
   parameter int CNT_W      = CNT_W_DEF
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [PARAM_W-1:0]    i_p, i_t, i_q, i_r, i_e, i_stride,
   input  logic [PARAM_W-1:0]    i_filt_row, i_filt_col, i_ifmap_col, i_ofmap_col,
   output logic [GLB_ADDR_W-1:0] o_base,
   output logic [CNT_W-1:0]      o_total,
   output logic                  o_calc_done
);
   logic [PARAM_W-1:0] r_p, r_t, r_q, r_r, r_e, r_stride;
   logic [PARAM_W-1:0] r_filt_row, r_filt_col, r_ifmap_col, r_ofmap_col;
   logic [CALC_W-1:0]  r_pt, r_qr, r_span, r_ecol;
   logic               r_calc1, r_calc2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {r_p, r_t, r_q, r_r, r_e, r_stride} <= '0;
         {r_filt_row, r_filt_col, r_ifmap_col, r_ofmap_col} <= '0;
         {r_pt, r_qr, r_span, r_ecol} <= '0;
         r_calc1 <= 1'b0;
         r_calc2 <= 1'b0;
      end else begin
         r_calc1 <= i_start;
         r_calc2 <= r_calc1;
         if (i_start) begin
            {r_p, r_t, r_q, r_r, r_e, r_stride} <= {i_p, i_t, i_q, i_r, i_e, i_stride};
            {r_filt_row, r_filt_col, r_ifmap_col, r_ofmap_col} <=
               {i_filt_row, i_filt_col, i_ifmap_col, i_ofmap_col};
         end
         if (r_calc1) begin
            r_pt   <= CALC_W'(r_p) * CALC_W'(r_t);
            r_qr   <= CALC_W'(r_q) * CALC_W'(r_r);
            r_span <= CALC_W'(r_stride) * (CALC_W'(r_e) - CALC_W'(1)) + CALC_W'(r_filt_col);
            r_ecol <= CALC_W'(r_e) * CALC_W'(r_ofmap_col);
         end
      end
   end

   // Second stage is combinational; the top registers it when leaving CALC2.
   assign o_base = GLB_ADDR_W'(r_qr * r_span * CALC_W'(r_ifmap_col)
                               + r_pt * r_qr * CALC_W'(r_filt_row) * CALC_W'(r_filt_col)
                               + r_pt * CALC_W'(BYTES_PER_WORD));
   assign o_total     = CNT_W'(r_pt * r_ecol);
   assign o_calc_done = r_calc2;
endmodule

// File: rtl/opsum_glb_writer.sv
// rtl/opsum_glb_writer.sv - streams 32-bit opsums little-endian into the GLB; OPSUM_RELU_EN clamps negatives to 0
module opsum_glb_writer
   import opsum_pkg::*;
#(
   parameter int PARAM_W    = PARAM_W_DEF,
   parameter int GLB_ADDR_W = GLB_ADDR_W_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DATA_W     = DATA_W_DEF
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [PARAM_W-1:0] i_p, i_t, i_q, i_r, i_e, i_stride,
   input  logic [PARAM_W-1:0] i_filt_row, i_filt_col, i_ifmap_col, i_ofmap_col,
   opsum_glb_writer_if.master bus,
   output logic               o_busy,
   output logic               o_done
);
   state_t                r_state, w_next;
   logic [GLB_ADDR_W-1:0] r_wptr, r_addr, w_base;
   logic [CNT_W-1:0]      r_cnt, r_total, w_total;
   logic [DATA_W-1:0]     r_wdata, w_wdata;
   logic                  r_we, w_start, w_ready, w_hs, w_calc_done;

   assign w_start = i_start && (r_state == IDLE || r_state == DONE);
   assign w_ready = (r_state == WRITE) && (r_cnt < r_total);
   assign w_hs    = bus.opsum_valid && w_ready;

`ifdef OPSUM_RELU_EN
   assign w_wdata = bus.opsum_data[DATA_W-1] ? '0 : bus.opsum_data;
`else
   assign w_wdata = bus.opsum_data;
`endif

   opsum_addr_calc #(.PARAM_W(PARAM_W), .GLB_ADDR_W(GLB_ADDR_W), .CNT_W(CNT_W)) u_calc (
      .clk(clk), .rst(rst), .i_start(w_start),
      .i_p(i_p), .i_t(i_t), .i_q(i_q), .i_r(i_r), .i_e(i_e), .i_stride(i_stride),
      .i_filt_row(i_filt_row), .i_filt_col(i_filt_col),
      .i_ifmap_col(i_ifmap_col), .i_ofmap_col(i_ofmap_col),
      .o_base(w_base), .o_total(w_total), .o_calc_done(w_calc_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         IDLE:  if (w_start) w_next = CALC1;
         CALC1: begin o_busy = 1'b1; w_next = CALC2; end
         CALC2: begin
            o_busy = 1'b1;
            if (w_calc_done) w_next = (w_total == '0) ? DONE : WRITE;
         end
         WRITE: begin
            o_busy = 1'b1;
            if (w_hs && (r_cnt + CNT_W'(1) == r_total)) w_next = DRAIN;
         end
         DRAIN: begin o_busy = 1'b1; w_next = DONE; end
         DONE:  begin o_done = 1'b1; if (w_start) w_next = CALC1; end
         default: w_next = IDLE;
      endcase
   end

   // Write port is registered: a handshake in cycle N becomes a GLB write in N+1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wptr  <= '0;
         r_cnt   <= '0;
         r_total <= '0;
      end else begin
         r_we <= w_hs;
         if (r_state == CALC2 && w_calc_done) begin
            r_wptr  <= w_base;
            r_cnt   <= '0;
            r_total <= w_total;
         end else if (w_hs) begin
            r_addr  <= r_wptr;
            r_wdata <= w_wdata;
            r_wptr  <= r_wptr + GLB_ADDR_W'(BYTES_PER_WORD);
            r_cnt   <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.opsum_ready = w_ready;
   assign bus.glb_we      = r_we;
   assign bus.glb_addr    = r_addr;
   assign bus.glb_wdata   = r_wdata;
endmodule

// File: tb/tb_opsum_glb_writer.sv
// tb/tb_opsum_glb_writer.sv - self-checking bench for opsum_glb_writer
module tb_opsum_glb_writer;
   typedef struct {int p, t, q, r, e, stride, fr, fc, ic, oc;} prm_t;
   typedef struct {prm_t prm; int gap; int exp_base; int exp_total;} vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_start;
   logic [7:0] i_p, i_t, i_q, i_r, i_e, i_stride, i_filt_row, i_filt_col, i_ifmap_col, i_ofmap_col;
   logic       o_busy, o_done;

   opsum_glb_writer_if #(.DATA_W(32), .GLB_ADDR_W(16)) bus ();

   opsum_glb_writer #(.PARAM_W(8), .GLB_ADDR_W(16), .CNT_W(16), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .i_start(i_start),
      .i_p(i_p), .i_t(i_t), .i_q(i_q), .i_r(i_r), .i_e(i_e), .i_stride(i_stride),
      .i_filt_row(i_filt_row), .i_filt_col(i_filt_col),
      .i_ifmap_col(i_ifmap_col), .i_ofmap_col(i_ofmap_col),
      .bus(bus), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [7:0]  mem [0:65535];
   int          wr_addr[$];
   int          wr_cyc[$];
   int          hs_cyc[$];
   logic [31:0] wr_data[$];
   logic [31:0] tx[$];

   // GLB model: byte memory fed from the write port, plus a log of every write
   always @(negedge clk) begin
      if (bus.glb_we === 1'b1) begin
         wr_addr.push_back(int'(bus.glb_addr));
         wr_data.push_back(bus.glb_wdata);
         wr_cyc.push_back(cyc_cnt);
         for (int k = 0; k < 4; k++)
            mem[16'(bus.glb_addr + 16'(k))] <= bus.glb_wdata[8*k +: 8];
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic prm_t mk(int p, int t, int q, int r, int e, int s,
                               int fr, int fc, int ic, int oc);
      prm_t x;
      x.p = p; x.t = t; x.q = q; x.r = r; x.e = e; x.stride = s;
      x.fr = fr; x.fc = fc; x.ic = ic; x.oc = oc;
      return x;
   endfunction

   function automatic prm_t rand_prm();
      return mk($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 4), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 4));
   endfunction

   // Region layout straight from the mapping rules, reduced modulo the 16-bit address/count space
   function automatic int model_base(prm_t x);
      int pt = x.p * x.t;
      int qr = x.q * x.r;
      int ifmap_rows = x.stride * (x.e - 1) + x.fc;
      return (qr * ifmap_rows * x.ic + pt * qr * x.fr * x.fc + pt * 4) & 32'hFFFF;
   endfunction

   function automatic int model_total(prm_t x);
      return (x.p * x.t * x.e * x.oc) & 32'hFFFF;
   endfunction

   function automatic logic [31:0] model_data(logic [31:0] w);
`ifdef OPSUM_RELU_EN
      return ($signed(w) < 0) ? 32'h0 : w;
`else
      return w;
`endif
   endfunction

   task automatic set_prm(prm_t x);
      i_p = 8'(x.p); i_t = 8'(x.t); i_q = 8'(x.q); i_r = 8'(x.r); i_e = 8'(x.e);
      i_stride = 8'(x.stride); i_filt_row = 8'(x.fr); i_filt_col = 8'(x.fc);
      i_ifmap_col = 8'(x.ic); i_ofmap_col = 8'(x.oc);
   endtask

   // gap: 0 = valid every cycle, 1 = pattern 1,0,0, 2 = random; inj = word index at which to pulse start
   task automatic stream(input int n, input int gap, input int inj, output int got);
      int   it = 0;
      bit   injd = 0;
      logic v;
      got = 0;
      while (got < n && it < 20 * n + 50) begin
         @(negedge clk);
         case (gap)
            0:       v = 1'b1;
            1:       v = (it % 3 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.opsum_valid = v;
         bus.opsum_data  = tx[got];
         i_start = 1'b0;
         if (inj >= 0 && got == inj && !injd) begin
            i_start = 1'b1;
            injd = 1'b1;
         end
         if (v && bus.opsum_ready === 1'b1) begin
            hs_cyc.push_back(cyc_cnt);
            got++;
         end
         it++;
      end
   endtask

   task automatic run_pass(input string nm, input prm_t x, input int gap,
                           input int exp_base, input int exp_total, input int inj);
      int   s, got, rdy_late, done_cyc, exp_done;
      logic was_done;
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); hs_cyc.delete();
      @(negedge clk);
      was_done = o_done;
      set_prm(x);
      i_start = 1'b1;
      s = cyc_cnt;
      @(negedge clk);
      i_start = 1'b0;
      chk({nm, ".busy"}, o_busy, 1);
      if (was_done) chk({nm, ".done_clr"}, o_done, 0);
      set_prm(rand_prm());
      stream(exp_total, gap, inj, got);
      chk({nm, ".accepted"}, got, exp_total);
      i_start = 1'b0;
      bus.opsum_valid = 1'b1;
      rdy_late = 0;
      done_cyc = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.opsum_ready === 1'b1) rdy_late++;
         if (o_done === 1'b1) begin
            done_cyc = cyc_cnt;
            break;
         end
      end
      bus.opsum_valid = 1'b0;
      chk({nm, ".ready_after"}, rdy_late, 0);
      exp_done = (exp_total == 0 || hs_cyc.size() == 0) ? s + 3 : hs_cyc[hs_cyc.size()-1] + 2;
      chk({nm, ".done_cyc"}, done_cyc, exp_done);
      chk({nm, ".busy_end"}, o_busy, 0);
      chk({nm, ".n_writes"}, wr_addr.size(), exp_total);
      for (int i = 0; i < wr_addr.size() && i < exp_total; i++) begin
         chk($sformatf("%s.addr%0d", nm, i), wr_addr[i], (exp_base + 4 * i) & 32'hFFFF);
         chk($sformatf("%s.data%0d", nm, i), wr_data[i], model_data(tx[i]));
         if (i < hs_cyc.size())
            chk($sformatf("%s.lat%0d", nm, i), wr_cyc[i], hs_cyc[i] + 1);
      end
      if (gap == 0 && exp_total > 1 && hs_cyc.size() == exp_total)
         chk({nm, ".b2b"}, hs_cyc[exp_total-1] - hs_cyc[0], exp_total - 1);
   endtask

   task automatic fill_seq(int n);
      tx.delete();
      for (int i = 0; i < n; i++) tx.push_back(32'h11111111 * (i + 1));
   endtask

   task automatic fill_rand(int n);
      tx.delete();
      for (int i = 0; i < n; i++) tx.push_back($urandom);
   endtask

   vec_t tbl[6];
   prm_t base_prm;
   int   got;

   initial begin
      base_prm = mk(1, 1, 1, 1, 2, 1, 3, 3, 5, 3);
      tbl[0] = '{prm: base_prm, gap: 0, exp_base: 33, exp_total: 6};
      tbl[1] = '{prm: base_prm, gap: 1, exp_base: 33, exp_total: 6};
      tbl[2] = '{prm: mk(2, 1, 1, 1, 2, 1, 3, 3, 5, 3), gap: 0, exp_base: 46, exp_total: 12};
      tbl[3] = '{prm: mk(1, 2, 1, 2, 3, 2, 2, 2, 7, 2), gap: 2, exp_base: 108, exp_total: 12};
      tbl[4] = '{prm: mk(1, 1, 1, 1, 2, 1, 3, 3, 5, 0), gap: 0, exp_base: 33, exp_total: 0};
      tbl[5] = '{prm: mk(1, 1, 16, 16, 2, 1, 1, 255, 1, 35), gap: 2, exp_base: 65284, exp_total: 70};

      rst = 1'b1;
      i_start = 1'b0;
      set_prm(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      bus.opsum_valid = 1'b0;
      bus.opsum_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst.ctl", {bus.glb_we, bus.opsum_ready, o_busy, o_done}, 0);
      chk("rst.addr", bus.glb_addr, 0);
      chk("rst.wdata", bus.glb_wdata, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle.ctl", {bus.glb_we, bus.opsum_ready, o_busy, o_done}, 0);

      for (int i = 0; i < 6; i++) begin
         if (i < 2) fill_seq(tbl[i].exp_total);
         else       fill_rand(tbl[i].exp_total);
         run_pass($sformatf("vec%0d", i), tbl[i].prm, tbl[i].gap,
                  tbl[i].exp_base, tbl[i].exp_total, -1);
      end
      chk("glb.bytes33", {mem[36], mem[35], mem[34], mem[33]}, 32'h11111111);

      fill_seq(6);
      run_pass("ign_start", base_prm, 0, 33, 6, 2);
      fill_rand(6);
      run_pass("restart", base_prm, 1, 33, 6, -1);

      tx.delete();
      tx.push_back(32'hFFFFFFF0); tx.push_back(32'h7FFFFFFF); tx.push_back(32'h80000000);
      tx.push_back(32'h00000000); tx.push_back(32'h12345678); tx.push_back(32'h00000001);
      run_pass("relu", base_prm, 0, 33, 6, -1);
`ifdef OPSUM_RELU_EN
      if (wr_data.size() > 1) chk("relu.neg", wr_data[0], 32'h00000000);
`else
      if (wr_data.size() > 1) chk("relu.neg", wr_data[0], 32'hFFFFFFF0);
`endif
      if (wr_data.size() > 1) chk("relu.pos", wr_data[1], 32'h7FFFFFFF);
      chk("glb.le_lo", mem[49], 8'h78);
      chk("glb.le_hi", mem[52], 8'h12);

      fill_seq(6);
      @(negedge clk);
      set_prm(base_prm);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      hs_cyc.delete();
      stream(3, 0, -1, got);
      chk("midrst.accepted", got, 3);
      @(negedge clk);
      bus.opsum_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst.ctl", {bus.glb_we, bus.opsum_ready, o_busy, o_done}, 0);
      chk("midrst.addr", bus.glb_addr, 0);
      chk("midrst.wdata", bus.glb_wdata, 0);
      @(negedge clk);
      rst = 1'b0;
      fill_rand(12);
      run_pass("after_rst", tbl[2].prm, 0, 46, 12, -1);

      for (int i = 0; i < 6; i++) begin
         prm_t x = rand_prm();
         fill_rand(model_total(x));
         run_pass($sformatf("rnd%0d", i), x, 2, model_base(x), model_total(x), -1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/opsum_glb_writer.md
Name: opsum_glb_writer

Overview:
- Write-side counterpart to the result readout path: accepts 32-bit output partial sums (opsums) from the PE array over a valid/ready stream.
- Stores each word little-endian into the byte-addressed GLB, in the opsum region.
- Computes the region base address from the mapping parameters: word i goes to byte address base + 4*i.
- Raises a level `done` once all p*t*e*ofmap_col words are committed; the top-level `done` is driven from it.

Parameters:
- PARAM_W, 8, width of each mapping parameter input
- GLB_ADDR_W, 16, GLB byte-address width (64 KiB)
- CNT_W, 16, opsum word counter width
- DATA_W, 32, opsum word width (fixed 32; 4 GLB bytes)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; latches parameters and begins a pass
- p, t, q, r, e, stride, filt_row, filt_col, ifmap_col, ofmap_col  in  PARAM_W each  mapping parameters, sampled on start
- opsum_valid  in  1  opsum word available
- opsum_data  in  DATA_W  opsum word
- opsum_ready  out  1  writer accepts the word this cycle
- glb_we  out  1  GLB write strobe; writes 4 bytes
- glb_addr  out  GLB_ADDR_W  byte address of byte 0 (LSB)
- glb_wdata  out  DATA_W  bytes [7:0]→addr, [15:8]→addr+1, [23:16]→addr+2, [31:24]→addr+3
- busy  out  1  pass in progress
- done  out  1  level; all words committed

Behaviour:
- Reset (async, any state): state=IDLE. Outputs: glb_we=0, glb_addr=0, glb_wdata=0, opsum_ready=0, busy=0, done=0. Counters and latched parameters are cleared.
- States are IDLE, CALC1, CALC2, WRITE, DRAIN, DONE.
- IDLE: start=1 latches the params and moves to CALC1. busy=1 from the next cycle.
- CALC1 registers the products pt=p*t, qr=q*r, span=stride*(e-1)+filt_col, and ecol=e*ofmap_col.
- CALC2 computes:
  - base = qr*span*ifmap_col + pt*qr*filt_row*filt_col + pt*4
  - total = pt*ecol
  - Width rules: intermediates use full-width unsigned arithmetic, then truncate to GLB_ADDR_W and CNT_W. Overflow is not flagged.
  - Transition: total==0 → DONE; otherwise → WRITE with wptr=base and cnt=0.
- WRITE:
  - opsum_ready = 1 while cnt<total.
  - A handshake (valid&ready) at cycle N produces glb_we=1 at N+1 with glb_addr=wptr and glb_wdata=data (or the ReLU result). wptr advances by 4 and cnt by 1.
  - Addresses wrap modulo 2^GLB_ADDR_W.
  - Back-to-back acceptance every cycle is required; the sustained rate is 1 word/cycle.
  - The handshake that brings cnt to total moves to DRAIN, and opsum_ready drops in the same cycle as that transition.
- DRAIN: the final glb_we is issued in this cycle, then → DONE.
- DONE: done=1 and busy=0 until the next start. A start here clears done in the following cycle and behaves as in IDLE.
- glb_we is 0 in every state except the cycle after a handshake.
- opsum_valid while not in WRITE: ignored, never accepted.
- start while busy (CALC1..DRAIN): ignored. The parameters are not re-latched.
- Parameter inputs changing mid-pass have no effect.

Optional Feature:
- Macro: OPSUM_RELU_EN.
- When defined: opsum_data is treated as signed two's complement. Negative words are written as 0x00000000; non-negative words pass unchanged. Latency is unchanged.
- When undefined: words are written bit-exact.

Decomposition:
- Shared package opsum_pkg holds:
  - the state enum (IDLE..DONE)
  - BYTES_PER_WORD=4
  - default widths
  - a function computing base/total for bench reuse
- One natural sub-module, opsum_addr_calc, holds the CALC1/CALC2 registered arithmetic. It takes the parameters plus a start pulse and returns base, total and calc_done.

Test Plan:
- Single pass:
  - Stimulus: p=t=q=r=stride=1, e=2, filt_row=filt_col=3, ifmap_col=5, ofmap_col=3; words 0x11111111..0x66666666 streamed back-to-back.
  - Response: base=33; glb_we on six consecutive cycles at addresses 33,37,41,45,49,53; done=1 two cycles after the 6th handshake; GLB bytes at 33..36 = 11 11 11 11.
- Backpressure gaps: same params, opsum_valid toggled 1,0,0,1,... → addresses still contiguous (+4 per word); no write in gap cycles; cnt ends at 6.
- Zero total: ofmap_col=0 → opsum_ready never asserts; done=1 three cycles after start; no glb_we.
- Reset mid-pass: assert rst after 3 of 6 words → all outputs 0 immediately. A new start with p=2 (other params as in the single-pass case) → base=2*(... )=recomputed 20+18+8=46; 12 writes from 46.
- Start ignored / restart: a start pulse during WRITE leaves cnt and addresses unchanged. A start in DONE clears done next cycle and a second identical pass rewrites 33..53.
- OPSUM_RELU_EN: word 0xFFFFFFF0 written as 0x00000000 and 0x7FFFFFFF unchanged. With the macro undefined, 0xFFFFFFF0 is written unchanged.
